// File: rtl/sub_16_serial.sv
// Digit-serial 16-bit subtractor: diff = a - b - b_in, DIGIT_W bits per cycle, LSB digit first.
// Define SUB_16_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module sub_16_serial #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        b_in,
    output logic [15:0] diff,
    output logic        b_out,
    output logic        busy,
    output logic        done
`ifdef SUB_16_SERIAL_OVF_EN
    ,
    output logic        ovf
`endif
);

    localparam int         N      = 16 / DIGIT_W;
    localparam logic [4:0] N_LAST = 5'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_acc;
    logic        r_borrow;
    logic [4:0]  r_cnt;
`ifdef SUB_16_SERIAL_OVF_EN
    logic        r_a_msb;
    logic        r_b_msb;
`endif

    logic [DIGIT_W:0] w_sub;
    logic [15:0]      w_top;
    logic [15:0]      w_acc_next;

    // The extra top bit of the digit difference is the borrow into the next digit.
    assign w_sub      = {1'b0, r_a[DIGIT_W-1:0]} - {1'b0, r_b[DIGIT_W-1:0]}
                        - {{DIGIT_W{1'b0}}, r_borrow};
    assign w_top      = 16'(w_sub[DIGIT_W-1:0]) << (16 - DIGIT_W);
    assign w_acc_next = (r_acc >> DIGIT_W) | w_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SUB_16_SERIAL_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= b_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
`ifdef SUB_16_SERIAL_OVF_EN
                        r_a_msb  <= a[15];
                        r_b_msb  <= b[15];
`endif
                    end
                end
                RUN: begin
                    // Outputs only change here, once every digit has been accumulated.
                    if (r_cnt == N_LAST) begin
                        diff    <= r_acc;
                        b_out   <= r_borrow;
                        done    <= 1'b1;
                        r_state <= DONE;
`ifdef SUB_16_SERIAL_OVF_EN
                        ovf     <= (r_a_msb != r_b_msb) && (r_acc[15] != r_a_msb);
`endif
                    end else begin
                        r_acc    <= w_acc_next;
                        r_borrow <= w_sub[DIGIT_W];
                        r_a      <= r_a >> DIGIT_W;
                        r_b      <= r_b >> DIGIT_W;
                        r_cnt    <= r_cnt + 5'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_16_serial.sv
// Bench for sub_16_serial: one instance per legal DIGIT_W, all driven together and
// compared cycle by cycle against a plain-arithmetic reference.
module tb_sub_16_serial;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;

    logic [15:0] w_diff [NI];
    logic        w_bout [NI];
    logic        w_busy [NI];
    logic        w_done [NI];
`ifdef SUB_16_SERIAL_OVF_EN
    logic        w_ovf  [NI];
`endif

    logic [15:0] exp_diff [NI];
    logic        exp_bout [NI];
    logic        exp_ovf  [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_16_serial #(.DIGIT_W(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start),
            .a     (a),
            .b     (b),
            .b_in  (b_in),
            .diff  (w_diff[g]),
            .b_out (w_bout[g]),
            .busy  (w_busy[g]),
            .done  (w_done[g])
`ifdef SUB_16_SERIAL_OVF_EN
            ,
            .ovf   (w_ovf[g])
`endif
        );
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s dw=%0d observed=%0h expected=%0h", tag, 1 << idx, obs, expv);
        end
    endtask

    task automatic chk_outputs(input int i);
        chk("diff", i, 32'(w_diff[i]), 32'(exp_diff[i]));
        chk("b_out", i, 32'(w_bout[i]), 32'(exp_bout[i]));
`ifdef SUB_16_SERIAL_OVF_EN
        chk("ovf", i, 32'(w_ovf[i]), 32'(exp_ovf[i]));
`endif
    endtask

    task automatic model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                         output logic [15:0] md, output logic mb, output logic mo);
        int r;
        r  = int'(ta) - int'(tb_) - int'(tbin);
        md = r[15:0];
        mb = (r < 0);
        mo = (ta[15] != tb_[15]) && (md[15] != ta[15]);
    endtask

    // One operation; scramble keeps start high and changes operands while busy.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin, input bit scramble);
        logic [15:0] nd;
        logic        nb;
        logic        no;
        int          n;
        model(ta, tb_, tbin, nd, nb, no);
        a     = ta;
        b     = tb_;
        b_in  = tbin;
        start = 1'b1;
        @(posedge clk); #1;
        start = scramble;
        a     = 16'($urandom);
        b     = 16'($urandom);
        b_in  = 1'($urandom);
        for (int j = 1; j <= 18; j++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                n = 16 >> i;
                if (j == n + 1) begin
                    exp_diff[i] = nd;
                    exp_bout[i] = nb;
                    exp_ovf[i]  = no;
                end
                chk("done", i, 32'(w_done[i]), 32'(j == n + 1));
                chk("busy", i, 32'(w_busy[i]), 32'(j <= n + 1));
                chk_outputs(i);
            end
            start = scramble && (j <= 2);
            a     = 16'($urandom);
            b     = 16'($urandom);
            b_in  = 1'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] nd;
        logic        nb;
        logic        no;
        int          n;
        int          ph;
        logic [15:0] ra;
        logic [15:0] rb;

        for (int i = 0; i < NI; i++) begin
            exp_diff[i] = '0;
            exp_bout[i] = 1'b0;
            exp_ovf[i]  = 1'b0;
        end
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, 32'(w_busy[i]), 32'd0);
            chk("rst_done", i, 32'(w_done[i]), 32'd0);
            chk_outputs(i);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, including wrap and borrow boundaries.
        run_op(16'h0007, 16'h0004, 1'b0, 1'b0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        run_op(16'h0401, 16'h00FF, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h8000, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b0, 1'b0);

        // start re-asserted with other operands during the operation
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);

        // start held high: a new operation begins on the first IDLE cycle after each DONE
        ra = 16'h4321;
        rb = 16'h1357;
        model(ra, rb, 1'b1, nd, nb, no);
        a     = ra;
        b     = rb;
        b_in  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                n  = 16 >> i;
                ph = j - (n + 1);
                if (j == n + 1) begin
                    exp_diff[i] = nd;
                    exp_bout[i] = nb;
                    exp_ovf[i]  = no;
                end
                chk("held_done", i, 32'(w_done[i]), 32'(ph >= 0 && (ph % (n + 3)) == 0));
                chk("held_busy", i, 32'(w_busy[i]), 32'(!(ph >= 1 && (ph % (n + 3)) == 1)));
                chk_outputs(i);
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("held_idle", i, 32'(w_busy[i]), 32'd0);
            chk_outputs(i);
        end

        // Reset during RUN aborts with outputs cleared at once and no done pulse.
        a     = 16'hBEEF;
        b     = 16'h0123;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            exp_diff[i] = '0;
            exp_bout[i] = 1'b0;
            exp_ovf[i]  = 1'b0;
            chk("arst_busy", i, 32'(w_busy[i]), 32'd0);
            chk("arst_done", i, 32'(w_done[i]), 32'd0);
            chk_outputs(i);
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) chk("arst_hold_done", i, 32'(w_done[i]), 32'd0);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                chk("post_rst_done", i, 32'(w_done[i]), 32'd0);
                chk("post_rst_busy", i, 32'(w_busy[i]), 32'd0);
            end
        end
        run_op(16'h0008, 16'h0007, 1'b0, 1'b0);

        // Randomized operations, some with start re-asserted while busy.
        for (int k = 0; k < 24; k++) begin
            run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
